// File: rtl/a_n_rca_pkg.sv
// Shared constants for the ripple-carry adder slice.
package a_n_rca_pkg;
  localparam int unsigned N_DEFAULT = 4;
  localparam int unsigned N_MIN     = 1;
  localparam int unsigned N_MAX     = 64;
endpackage

// File: rtl/a_n_rca_full_adder.sv
// One-bit full-adder cell; the building block of the ripple chain.
module full_adder
  import a_n_rca_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  logic prop_s;

  assign prop_s = a ^ b;
  assign sum    = prop_s ^ c_in;
  assign c_out  = (a & b) | (c_in & prop_s);
endmodule

// File: rtl/a_n_rca.sv
// n-bit ripple-carry adder with the sum and carry-out registered every clock.
module a_n_rca
  import a_n_rca_pkg::*;
#(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         c_in,
  output logic [n-1:0] sum,
  output logic         c_out
);
  logic [n:0]   carry_s;
  logic [n-1:0] sum_s;

  assign carry_s[0] = c_in;

  // Strictly ripple: each cell waits on the carry of the one below it.
  for (genvar i = 0; i < n; i++) begin : g_cell
    full_adder u_fa (
      .a     (a[i]),
      .b     (b[i]),
      .c_in  (carry_s[i]),
      .sum   (sum_s[i]),
      .c_out (carry_s[i+1])
    );
  end

  // Result register: loads unconditionally each edge, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum   <= {n{1'b0}};
      c_out <= 1'b0;
    end else begin
      sum   <= sum_s;
      c_out <= carry_s[n];
    end
  end
endmodule

// File: tb/tb_a_n_rca.sv
// Directed + exhaustive + random checks of a_n_rca at n=4, n=1 and n=16.
module tb_a_n_rca;
  logic        clk;
  logic        rst_n;
  logic [3:0]  a4, b4;
  logic        c4;
  logic [3:0]  sum4;
  logic        co4;
  logic [0:0]  a1, b1;
  logic        c1;
  logic [0:0]  sum1;
  logic        co1;
  logic [15:0] a16, b16;
  logic        c16;
  logic [15:0] sum16;
  logic        co16;

  int checks = 0;
  int errors = 0;

  a_n_rca #(.n(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .c_in(c4), .sum(sum4), .c_out(co4)
  );
  a_n_rca #(.n(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c_in(c1), .sum(sum1), .c_out(co1)
  );
  a_n_rca #(.n(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .c_in(c16), .sum(sum16), .c_out(co16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Sample point: 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] ref4(input int x, input int y, input int c);
    int s;
    s = (x + y + c) % 32;
    return 17'(s);
  endfunction

  function automatic logic [16:0] ref1(input int x, input int y, input int c);
    return 17'((x + y + c) % 4);
  endfunction

  function automatic logic [16:0] ref16(input int x, input int y, input int c);
    return 17'((x + y + c) % 131072);
  endfunction

  function automatic logic [16:0] obs4();
    return {12'd0, co4, sum4};
  endfunction

  function automatic logic [16:0] obs1();
    return {15'd0, co1, sum1};
  endfunction

  function automatic logic [16:0] obs16();
    return {co16, sum16};
  endfunction

  initial begin
    int ra, rb, rc;
    rst_n = 1'b0;
    a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    a16 = 16'hFFFF; b16 = 16'hFFFF; c16 = 1'b1;

    // Reset held with max operands: outputs stay cleared
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset_hold4", obs4(), 17'd0);
      chk("reset_hold1", obs1(), 17'd0);
      chk("reset_hold16", obs16(), 17'd0);
    end

    // First capture after release
    rst_n = 1'b1;
    step();
    chk("release_max4", obs4(), ref4(15, 15, 1));
    chk("release_max16", obs16(), ref16(65535, 65535, 1));

    // Asynchronous clear between edges
    #2 rst_n = 1'b0;
    #1 chk("async_clr4", obs4(), 17'd0);
    chk("async_clr16", obs16(), 17'd0);
    #2 rst_n = 1'b1;

    // Carry ripples through every bit
    a4 = 4'hF; b4 = 4'h0; c4 = 1'b1;
    step();
    chk("carry_all", obs4(), 17'h10);

    // No carry, then inputs change mid-cycle; outputs must hold
    a4 = 4'h3; b4 = 4'h4; c4 = 1'b0;
    step();
    chk("no_carry", obs4(), 17'h07);
    #2 a4 = 4'hA; b4 = 4'h9; c4 = 1'b1;
    #4 chk("hold_mid", obs4(), 17'h07);
    step();
    chk("after_change", obs4(), ref4(10, 9, 1));

    // Maximum and top-bit carry
    a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
    step();
    chk("max", obs4(), 17'h1F);
    a4 = 4'h8; b4 = 4'h8; c4 = 1'b0;
    step();
    chk("msb_carry", obs4(), 17'h10);

    // Exhaustive n=4
    for (int v = 0; v < 512; v++) begin
      a4 = 4'(v % 16); b4 = 4'((v / 16) % 16); c4 = 1'(v / 256);
      step();
      chk("exh4", obs4(), ref4(v % 16, (v / 16) % 16, v / 256));
    end

    // Random sweep on n=1 and n=16
    for (int i = 0; i < 200; i++) begin
      ra = int'($urandom_range(65535, 0));
      rb = int'($urandom_range(65535, 0));
      rc = int'($urandom_range(1, 0));
      a16 = 16'(ra); b16 = 16'(rb); c16 = 1'(rc);
      a1 = 1'(ra % 2); b1 = 1'(rb % 2); c1 = 1'(rc);
      step();
      chk("rnd16", obs16(), ref16(ra, rb, rc));
      chk("rnd1", obs1(), ref1(ra % 2, rb % 2, rc));
    end

    // All-ones plus carry-in wraps to zero with carry out
    a16 = 16'hFFFF; b16 = 16'h0000; c16 = 1'b1;
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b1;
    step();
    chk("wrap16", obs16(), 17'h10000);
    chk("wrap1", obs1(), 17'h2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
